// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, datapath width and op legality helper
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_SLT;
    endfunction

endpackage

// File: rtl/alu_16bit.sv
// rtl/alu_16bit.sv - combinational 16-bit ALU core
//
// Ports:
//   a, b      operands
//   op        ALU control code (0..5 defined, others give 0)
//   result    ALU result
//   zero      result == 0
//   overflow  signed overflow for ADD/SUB, 0 otherwise
module alu_16bit
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [3:0]       op,
    output logic [ALU_W-1:0] result,
    output logic             zero,
    output logic             overflow
);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = a + b;
                overflow = (a[ALU_W-1] == b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
            end
            OP_SUB: begin
                result   = a - b;
                overflow = (a[ALU_W-1] != b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req      request vector
//   rr_ptr   index scanned first (highest priority this cycle)
//   enable   allows the grant to be issued
//   grant    one-hot grant (all zero when disabled or no request)
//   winner   binary index of the selected requester
//   found    some requester is valid
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               found
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        // Scan from rr_ptr with wraparound; first valid requester wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = enable && found && (winner == ID_W'(i));
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU with a registered response channel
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      per-requester request valid
//   req_ready      per-requester accept (at most one high)
//   req_a, req_b   packed operands, requester i at [16i+15:16i]
//   req_op         packed op codes, requester i at [4i+3:4i]
//   rsp_valid      response register holds a result
//   rsp_ready      consumer accepts the response
//   rsp_id         requester that produced the response
//   rsp_result     ALU result (0 for illegal ops)
//   rsp_zero       result == 0
//   rsp_overflow   signed overflow (ADD/SUB)
//   rsp_err        op code outside 0..5
//   op_count       saturating count of accepted requests
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ALU_W-1:0] req_a,
    input  logic [NUM_REQ*ALU_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]     req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [ALU_W-1:0]         rsp_result,
    output logic                     rsp_zero,
    output logic                     rsp_overflow,
    output logic                     rsp_err,
    output logic [CNT_W-1:0]         op_count
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [ALU_W-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic               can_issue;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               accept;

    logic [ALU_W-1:0] sel_a, sel_b;
    logic [3:0]       sel_op;
    logic [ALU_W-1:0] core_result;
    logic             core_zero, core_overflow;
    logic             op_err;
    logic [ALU_W-1:0] alu_result;
    logic             alu_zero, alu_overflow;

    // The output register can take new data when empty or when it drains this cycle.
    // Gating with rst_n keeps req_ready low while reset is held.
    assign can_issue = ((state_q == ST_EMPTY) || rsp_ready) && rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .enable (can_issue),
        .grant  (grant),
        .winner (winner),
        .found  (found)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a  = req_a[ALU_W*i +: ALU_W];
                sel_b  = req_b[ALU_W*i +: ALU_W];
                sel_op = req_op[4*i +: 4];
            end
        end
    end

    alu_16bit u_alu (
        .a        (sel_a),
        .b        (sel_b),
        .op       (sel_op),
        .result   (core_result),
        .zero     (core_zero),
        .overflow (core_overflow)
    );

    // Illegal op codes report err with a forced zero result and no overflow.
    assign op_err       = !is_legal_op(sel_op);
    assign alu_result   = op_err ? '0 : core_result;
    assign alu_zero     = op_err | core_zero;
    assign alu_overflow = !op_err & core_overflow;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_err_d      = rsp_err_q;
        op_count_d     = op_count_q;
        if (accept) begin
            state_d        = ST_FULL;
            rsp_id_d       = winner;
            rsp_result_d   = alu_result;
            rsp_zero_d     = alu_zero;
            rsp_overflow_d = alu_overflow;
            rsp_err_d      = op_err;
            rr_ptr_d       = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
            if (op_count_q != '1) begin
                op_count_d = op_count_q + CNT_W'(1);
            end
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            rr_ptr_q       <= '0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_err_q      <= rsp_err_d;
            op_count_q     <= op_count_d;
        end
    end

    assign rsp_valid    = (state_q == ST_FULL);
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural model
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready, req_ready2;
    logic [15:0] a_arr [3];
    logic [15:0] b_arr [3];
    logic [3:0]  op_arr [3];
    logic [47:0] req_a, req_b;
    logic [11:0] req_op;
    logic        rsp_ready;
    logic        rsp_valid, rsp_valid2;
    logic [1:0]  rsp_id, rsp_id2;
    logic [15:0] rsp_result, rsp_result2;
    logic        rsp_zero, rsp_zero2;
    logic        rsp_overflow, rsp_overflow2;
    logic        rsp_err, rsp_err2;
    logic [15:0] op_count;
    logic [3:0]  op_count2;

    int checks = 0;
    int errors = 0;

    assign req_a  = {a_arr[2], a_arr[1], a_arr[0]};
    assign req_b  = {b_arr[2], b_arr[1], b_arr[0]};
    assign req_op = {op_arr[2], op_arr[1], op_arr[0]};

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(3), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_err(rsp_err), .op_count(op_count)
    );

    alu_arbiter #(.NUM_REQ(3), .ID_W(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2),
        .rsp_result(rsp_result2), .rsp_zero(rsp_zero2), .rsp_overflow(rsp_overflow2),
        .rsp_err(rsp_err2), .op_count(op_count2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain signed integer arithmetic.
    function automatic void alu_ref(input int op, input int a, input int b,
                                    output int r, output int z, output int ov, output int er);
        int sa, sb, s;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        r = 0; ov = 0; er = 0; s = 0;
        case (op)
            0: begin s = sa + sb; r = (a + b) & 65535; ov = (s > 32767 || s < -32768) ? 1 : 0; end
            1: begin s = sa - sb; r = (a - b) & 65535; ov = (s > 32767 || s < -32768) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sa < sb) ? 1 : 0;
            default: er = 1;
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    function automatic int pick(input logic [2:0] v, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (v[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    // Model state: what the response register must hold after the latest edge.
    int m_full = 0, m_ptr = 0, m_id = 0, m_res = 0, m_zero = 0, m_ov = 0, m_err = 0, m_cnt = 0;

    always @(negedge clk) begin : compare
        int w, r, z, ov, er, can, exp_rdy;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_flags", {rsp_zero, rsp_overflow, rsp_err}, 0);
            chk("rst_op_count", op_count, 0);
            chk("rst_op_count_sat", op_count2, 0);
            m_full = 0; m_ptr = 0; m_id = 0; m_res = 0;
            m_zero = 0; m_ov = 0; m_err = 0; m_cnt = 0;
        end else begin
            w = pick(req_valid, m_ptr);
            can = (m_full == 0 || rsp_ready) ? 1 : 0;
            exp_rdy = (can != 0 && w >= 0) ? (1 << w) : 0;
            chk("req_ready", req_ready, exp_rdy);
            chk("req_ready_sat", req_ready2, exp_rdy);
            chk("rsp_valid", rsp_valid, m_full);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", rsp_zero, m_zero);
            chk("rsp_overflow", rsp_overflow, m_ov);
            chk("rsp_err", rsp_err, m_err);
            chk("op_count", op_count, (m_cnt > 65535) ? 65535 : m_cnt);
            chk("op_count_sat", op_count2, (m_cnt > 15) ? 15 : m_cnt);
            if (exp_rdy != 0) begin
                alu_ref(int'(op_arr[w]), int'(a_arr[w]), int'(b_arr[w]), r, z, ov, er);
                m_full = 1; m_id = w; m_res = r; m_zero = z; m_ov = ov; m_err = er;
                m_ptr = (w + 1) % 3;
                m_cnt++;
            end else if (m_full != 0 && rsp_ready) begin
                m_full = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r, z, ov, er;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_arr[i] = '0; b_arr[i] = '0; op_arr[i] = '0;
        end

        // Model pins
        alu_ref(0, 16'h7FFF, 16'h0001, r, z, ov, er);
        chk("ref_add_res", r, 16'h8000);
        chk("ref_add_ov", ov, 1);
        alu_ref(1, 16'h8000, 16'h0001, r, z, ov, er);
        chk("ref_sub_res", r, 16'h7FFF);
        chk("ref_sub_ov", ov, 1);
        alu_ref(5, 16'hFFFF, 16'h0001, r, z, ov, er);
        chk("ref_slt_res", r, 1);

        repeat (2) tick();
        chk("reset_valid", rsp_valid, 0);
        chk("reset_count", op_count, 0);
        rst_n = 1'b1;
        tick();

        // Reset while a response is stalled
        req_valid = 3'b010; a_arr[1] = 16'h0003; b_arr[1] = 16'h0004; op_arr[1] = 4'd0;
        tick();
        req_valid = 3'b000;
        chk("pre_rst_valid", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", rsp_valid, 0);
        chk("async_rst_result", rsp_result, 0);
        chk("async_rst_count", op_count, 0);
        tick();
        rst_n = 1'b1;

        // Round robin with all requesters holding SUB 5-5
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_arr[i] = 16'd5; b_arr[i] = 16'd5; op_arr[i] = 4'd1;
        end
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_grant", req_ready, 1 << (k % 3));
            tick();
            chk("rr_rsp_id", rsp_id, k % 3);
            chk("rr_rsp_zero", rsp_zero, 1);
            chk("rr_rsp_result", rsp_result, 0);
        end
        req_valid = 3'b000;
        chk("rr_op_count", op_count, 6);
        tick();

        // Single ADD from requester 1
        req_valid = 3'b010; a_arr[1] = 16'h7FFF; b_arr[1] = 16'h0001; op_arr[1] = 4'd0;
        tick();
        req_valid = 3'b000;
        chk("add_valid", rsp_valid, 1);
        chk("add_id", rsp_id, 1);
        chk("add_result", rsp_result, 16'h8000);
        chk("add_overflow", rsp_overflow, 1);
        chk("add_zero", rsp_zero, 0);
        tick();

        // Backpressure with SLT from requester 2
        rsp_ready = 1'b0;
        req_valid = 3'b100; a_arr[2] = 16'hFFFF; b_arr[2] = 16'h0001; op_arr[2] = 4'd5;
        tick();
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_req_ready", req_ready, 0);
            chk("bp_result", rsp_result, 1);
            chk("bp_id", rsp_id, 2);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_next_grant", req_ready, 3'b001);
        tick();
        req_valid = 3'b000;
        tick();

        // Illegal op from requester 0
        req_valid = 3'b001; a_arr[0] = 16'h1234; b_arr[0] = 16'h0042; op_arr[0] = 4'b1001;
        tick();
        req_valid = 3'b000;
        chk("ill_result", rsp_result, 0);
        chk("ill_zero", rsp_zero, 1);
        chk("ill_err", rsp_err, 1);
        chk("ill_overflow", rsp_overflow, 0);
        tick();

        // Randomized traffic, with one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            req_valid = 3'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            for (int i = 0; i < 3; i++) begin
                case ($urandom % 4)
                    0: a_arr[i] = 16'h7FFF;
                    1: a_arr[i] = 16'h8000;
                    default: a_arr[i] = 16'($urandom);
                endcase
                b_arr[i] = ($urandom % 4 == 0) ? a_arr[i] : 16'($urandom);
                op_arr[i] = ($urandom % 5 == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
            end
            if (c == 1500) begin
                #2;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        req_valid = 3'b000;
        rsp_ready = 1'b1;
        repeat (2) tick();
        chk("sat_op_count", op_count2, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 16-bit ALU core among NUM_REQ requesters using round-robin arbitration and per-requester valid/ready handshakes.
- Registers the ALU result, zero and overflow flags, plus the winning requester ID, into a single response channel with backpressure.
- Sits between the issue stages (decode, address generation, branch compare) and the shared alu_16bit core.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*16  operand A, requester i at bits [16i+15:16i].
- req_b  in  NUM_REQ*16  operand B, same packing.
- req_op  in  NUM_REQ*4  ALU control code, requester i at bits [4i+3:4i].
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that produced the response.
- rsp_result  out  16  ALU result.
- rsp_zero  out  1  result == 0.
- rsp_overflow  out  1  signed overflow (ADD/SUB only).
- rsp_err  out  1  op code outside 0..5; result forced to 0.
- op_count  out  CNT_W  number of accepted requests; saturates at all-ones.

Behaviour:
- Reset: all outputs go to 0; rr_ptr goes to 0; state goes to EMPTY. Reset is asynchronous and may assert at any cycle. Any in-flight response is discarded.
- ALU op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed).
  - ADD overflow: operand signs equal and result sign differs.
  - SUB overflow: operand signs differ and result sign differs from A.
  - AND, OR, XOR, SLT: overflow = 0.
  - Op codes 6..15: result = 0, zero = 1, overflow = 0, err = 1.
- Response register has two states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- can_issue = EMPTY or (FULL and rsp_ready).
- Arbitration is combinational each cycle:
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first i with req_valid[i] = 1 is the winner.
  - req_ready[winner] = can_issue; all other req_ready bits = 0.
- Accept means req_valid[i] and req_ready[i] are both high in cycle T. Then:
  - Operands go through the ALU combinationally.
  - Response fields are registered at the end of T, so rsp_valid = 1 in T+1 (latency 1).
  - rr_ptr becomes (winner + 1) mod NUM_REQ.
  - op_count increments unless it is already saturated.
- State transitions:
  - EMPTY → FULL on accept.
  - FULL with rsp_ready and an accept: stays FULL, new data loaded. Back-to-back throughput is 1 op/cycle.
  - FULL with rsp_ready and no accept: goes to EMPTY; response fields hold their last values.
  - FULL with rsp_ready = 0: holds; all response fields stay stable and req_ready = 0.
- rr_ptr is unchanged in any cycle with no accept.
- The requester-side handshake follows standard valid/ready rules. The arbiter never drops an accepted request and never issues a response twice.
- Requester inputs are sampled only in the accept cycle, so requesters may change their operands while stalled.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op-code constants: OP_ADD = 4'd0 … OP_SLT = 4'd5.
  - ALU_W = 16.
  - A function is_legal_op(op).
- One sub-module, rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and the binary winner index.
- Instantiate the team's alu_16bit core for the datapath. Mask err, zero and overflow in the wrapper logic above the core.

Test Plan:
- Reset mid-response: assert rst_n = 0 while rsp_valid = 1 and rsp_ready = 0 → all outputs 0 immediately (asynchronous). After release, the first accept goes to requester 0.
- Single ADD from requester 1: a = 0x7FFF, b = 0x0001, op = 0 → one cycle later rsp_valid = 1, rsp_id = 1, result = 0x8000, overflow = 1, zero = 0.
- Round-robin fairness: all three requesters hold valid continuously with SUB 5 - 5, rsp_ready = 1 → grants 0, 1, 2, 0, 1, 2 on consecutive cycles. Every response has result = 0x0000, zero = 1, overflow = 0. op_count = 6 after six cycles.
- Backpressure: rsp_ready = 0 for 4 cycles while requester 2 issues SLT a = 0xFFFF, b = 0x0001 → result 0x0001 held stable all 4 cycles with req_ready = 0. When rsp_ready returns to 1, the next grant is requester 0.
- Illegal op: requester 0 issues op = 4'b1001, a = 0x1234 → result = 0x0000, zero = 1, err = 1, overflow = 0.
- Counter saturation: with CNT_W = 4, issue 20 accepts → op_count stops at 0xF.
